// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: one request/response port in, four decoded
// APB slave windows out, with decode-miss and PREADY-timeout error reporting.
module apb_master_bridge #(
  parameter int          TIMEOUT = 16,
  parameter logic [19:0] BASE_HI = 20'h10000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  // Request: accepted on an edge where req && req_ready. The requester holds
  // req/req_write/req_addr/req_wdata until then. rsp_valid pulses once per
  // accepted request, with rsp_rdata/rsp_err valid in that cycle.
  input  logic        req,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic [3:0]  PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic [3:0]  PREADY
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  sel_idx;
  logic        hit;
  logic        sel_ready;
  logic        timeout_hit;
  logic [31:0] sel_rdata;

  // Bits [13:12] pick one of the four 4 KB windows; the rest must match the base.
  assign hit         = (req_addr[31:14] == BASE_HI[19:2]);
  assign sel_ready   = PREADY[sel_idx];
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
  assign req_ready   = (state == S_IDLE);

  always_comb begin
    sel_rdata = PRDATA0;
    case (sel_idx)
      2'd1:    sel_rdata = PRDATA1;
      2'd2:    sel_rdata = PRDATA2;
      2'd3:    sel_rdata = PRDATA3;
      default: sel_rdata = PRDATA0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = hit ? S_SETUP : S_ERR;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (sel_ready || timeout_hit) state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      sel_idx   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            PADDR   <= req_addr;
            PWDATA  <= req_wdata;
            PWRITE  <= req_write;
            sel_idx <= req_addr[13:12];
            if (hit) PSEL <= 4'b0001 << req_addr[13:12];
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
        end
        S_ACCESS: begin
          if (sel_ready) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? 32'd0 : sel_rdata;
            cnt       <= '0;
          end else if (timeout_hit) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic [31:0] prdata [4];
  logic [3:0]  PREADY = '0;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.TIMEOUT(TIMEOUT), .BASE_HI(20'h10000)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA0(prdata[0]), .PRDATA1(prdata[1]), .PRDATA2(prdata[2]), .PRDATA3(prdata[3]),
    .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: whole-transaction outcome from the address map and the
  // slave's wait-state count. lat = edges after the accept edge until rsp_valid.
  function automatic void model_txn(input logic wr, input logic [31:0] addr, input int waits,
                                    output int lat, output int psel_cyc, output int pen_cyc,
                                    output logic [31:0] rdata, output logic err);
    logic is_hit;
    int   n;
    is_hit = (addr >= 32'h1000_0000) && (addr < 32'h1000_4000);
    n = is_hit ? ((waits + 1 < TIMEOUT) ? waits + 1 : TIMEOUT) : 0;
    err = !is_hit || (waits + 1 > TIMEOUT);
    lat = is_hit ? n + 1 : 1;
    psel_cyc = is_hit ? n + 1 : 0;
    pen_cyc = n;
    rdata = (err || wr) ? 32'd0 : prdata[(addr - 32'h1000_0000) / 4096];
  endfunction

  // Drives one request and plays the addressed slave with `waits` wait states;
  // unselected PREADY bits are random noise. Records what the APB side did.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, output int lat, output int psel_cyc,
                        output int pen_cyc, output int bad, output int pulses,
                        output logic [31:0] rdata, output logic err,
                        output logic [31:0] paddr_s, output logic [31:0] pwdata_s,
                        output logic pwrite_s);
    int s;
    s = int'(addr[13:12]);
    lat = -1; psel_cyc = 0; pen_cyc = 0; bad = 0; pulses = 0;
    rdata = '0; err = 1'b0; paddr_s = '0; pwdata_s = '0; pwrite_s = 1'b0;
    @(negedge PCLK);
    for (int w = 0; w < 40 && !req_ready; w++) @(negedge PCLK);
    req = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    PREADY = 4'($urandom); PREADY[s] = 1'b0;
    @(posedge PCLK);
    #1 req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (k == 0) begin paddr_s = PADDR; pwdata_s = PWDATA; pwrite_s = PWRITE; end
      if (PSEL != 4'b0) begin
        psel_cyc++;
        if (PSEL != (4'b0001 << s) || PADDR != addr || PWDATA != wdata || PWRITE != wr) bad++;
      end
      if (PENABLE && PSEL == 4'b0) bad++;
      if (PSEL != 4'b0 && PENABLE) pen_cyc++;
      if (rsp_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; rdata = rsp_rdata; err = rsp_err; end
      end
      if (lat >= 0 && k > lat && (rsp_rdata !== rdata || rsp_err !== err)) bad++;
      PREADY = 4'($urandom);
      PREADY[s] = PSEL[s] && PENABLE && (pen_cyc > waits);
      if (lat >= 0 && k >= lat + 2) break;
    end
    PREADY = '0;
  endtask

  task automatic test_reset();
    if (PSEL !== 4'b0) begin errors++; $display("FAIL reset_psel got %h exp 0", PSEL); end
    checks++;
    if (PENABLE !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got pen=%b vld=%b err=%b exp 0", PENABLE, rsp_valid, rsp_err);
    end
    checks++;
    if (PADDR !== 32'b0 || rsp_rdata !== 32'b0) begin
      errors++; $display("FAIL reset_data got paddr=%h rdata=%h exp 0", PADDR, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++;
  endtask

  task automatic test_write_zero_wait();
    int lat, ps, pe, bad, pulses;
    logic [31:0] rd, pa, pw;
    logic er, pwr;
    do_txn(1'b1, 32'h1000_0004, 32'h0000_00A5, 0, lat, ps, pe, bad, pulses, rd, er, pa, pw, pwr);
    if (ps !== 2 || pe !== 1) begin errors++; $display("FAIL wr0_phases got psel=%0d pen=%0d exp 2 1", ps, pe); end
    checks++;
    if (pa !== 32'h1000_0004 || pw !== 32'hA5 || pwr !== 1'b1) begin
      errors++; $display("FAIL wr0_bus got %h %h %b exp 10000004 a5 1", pa, pw, pwr);
    end
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'b0) begin
      errors++; $display("FAIL wr0_rsp got lat=%0d err=%b rd=%h exp 2 0 0", lat, er, rd);
    end
    checks++;
    if (bad !== 0 || pulses !== 1) begin errors++; $display("FAIL wr0_proto got bad=%0d pulses=%0d exp 0 1", bad, pulses); end
    checks++;
  endtask

  task automatic test_read_wait();
    int lat, ps, pe, bad, pulses;
    logic [31:0] rd, pa, pw;
    logic er, pwr;
    prdata[2] = 32'hDEAD_BEEF; prdata[0] = 32'h1111_1111;
    do_txn(1'b0, 32'h1000_2008, 32'h0, 3, lat, ps, pe, bad, pulses, rd, er, pa, pw, pwr);
    if (pe !== 4 || ps !== 5) begin errors++; $display("FAIL rdw_phases got psel=%0d pen=%0d exp 5 4", ps, pe); end
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 5) begin
      errors++; $display("FAIL rdw_rsp got rd=%h err=%b lat=%0d exp deadbeef 0 5", rd, er, lat);
    end
    checks++;
    if (bad !== 0 || pulses !== 1) begin errors++; $display("FAIL rdw_proto got bad=%0d pulses=%0d exp 0 1", bad, pulses); end
    checks++;
  endtask

  task automatic test_decode_miss();
    int lat, ps, pe, bad, pulses;
    logic [31:0] rd, pa, pw;
    logic er, pwr;
    do_txn(1'b0, 32'h2000_0000, 32'h0, 0, lat, ps, pe, bad, pulses, rd, er, pa, pw, pwr);
    if (ps !== 0 || pe !== 0) begin errors++; $display("FAIL miss_apb got psel=%0d pen=%0d exp 0 0", ps, pe); end
    checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'b0) begin
      errors++; $display("FAIL miss_rsp got lat=%0d err=%b rd=%h exp 1 1 0", lat, er, rd);
    end
    checks++;
    if (pa !== 32'h2000_0000 || pulses !== 1) begin errors++; $display("FAIL miss_latch got paddr=%h pulses=%0d exp 20000000 1", pa, pulses); end
    checks++;
  endtask

  task automatic test_timeout();
    int lat, ps, pe, bad, pulses;
    logic [31:0] rd, pa, pw;
    logic er, pwr;
    do_txn(1'b0, 32'h1000_3000, 32'h0, 1000, lat, ps, pe, bad, pulses, rd, er, pa, pw, pwr);
    if (pe !== TIMEOUT) begin errors++; $display("FAIL tmo_len got %0d exp %0d", pe, TIMEOUT); end
    checks++;
    if (er !== 1'b1 || rd !== 32'b0 || lat !== TIMEOUT + 1) begin
      errors++; $display("FAIL tmo_rsp got err=%b rd=%h lat=%0d exp 1 0 %0d", er, rd, lat, TIMEOUT + 1);
    end
    checks++;
    if (bad !== 0 || pulses !== 1 || PSEL !== 4'b0 || PENABLE !== 1'b0) begin
      errors++; $display("FAIL tmo_drop got bad=%0d pulses=%0d psel=%h exp 0 1 0", bad, pulses, PSEL);
    end
    checks++;
  endtask

  task automatic test_random();
    int lat, ps, pe, bad, pulses, waits;
    int e_lat, e_ps, e_pe;
    logic [31:0] rd, pa, pw, addr, wdata, e_rd;
    logic er, pwr, wr, e_er;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) prdata[i] = $urandom;
      wr = 1'($urandom);
      wdata = $urandom;
      if ($urandom_range(0, 4) == 0) addr = $urandom;
      else addr = 32'h1000_0000 + 32'($urandom_range(0, 16383));
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 30) : $urandom_range(0, 4);
      model_txn(wr, addr, waits, e_lat, e_ps, e_pe, e_rd, e_er);
      do_txn(wr, addr, wdata, waits, lat, ps, pe, bad, pulses, rd, er, pa, pw, pwr);
      if (lat !== e_lat || ps !== e_ps || pe !== e_pe) begin
        errors++; $display("FAIL rnd%0d_timing got %0d/%0d/%0d exp %0d/%0d/%0d", t, lat, ps, pe, e_lat, e_ps, e_pe);
      end
      checks++;
      if (rd !== e_rd || er !== e_er) begin
        errors++; $display("FAIL rnd%0d_rsp got rd=%h err=%b exp %h %b", t, rd, er, e_rd, e_er);
      end
      checks++;
      if (pa !== addr || pw !== wdata || pwr !== wr || bad !== 0 || pulses !== 1) begin
        errors++; $display("FAIL rnd%0d_bus got %h %h %b bad=%0d p=%0d exp %h %h %b 0 1", t, pa, pw, pwr, bad, pulses, addr, wdata, wr);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    int rsp_k[$];
    logic [31:0] pa2, pw2;
    pat = '0; pa2 = '0; pw2 = '0;
    @(negedge PCLK);
    req = 1'b1; req_write = 1'b1; req_addr = 32'h1000_1010; req_wdata = 32'h0BAD_0001;
    PREADY = 4'hF;
    @(posedge PCLK);
    for (int k = 0; k < 8; k++) begin
      @(negedge PCLK);
      pat[k] = |PSEL;
      if (rsp_valid) rsp_k.push_back(k);
      if (k == 0) begin req_addr = 32'h1000_1020; req_wdata = 32'h0BAD_0002; end
      if (k == 3) begin req = 1'b0; pa2 = PADDR; pw2 = PWDATA; end
    end
    PREADY = '0;
    if (pat !== 8'b0001_1011) begin errors++; $display("FAIL b2b_psel got %b exp 00011011", pat); end
    checks++;
    if (rsp_k.size() != 2 || rsp_k[0] != 2 || rsp_k[1] != 5) begin
      errors++; $display("FAIL b2b_rsp got n=%0d exp pulses at 2 and 5", rsp_k.size());
    end
    checks++;
    if (pa2 !== 32'h1000_1020 || pw2 !== 32'h0BAD_0002) begin
      errors++; $display("FAIL b2b_second got %h %h exp 10001020 0bad0002", pa2, pw2);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int lat, ps, pe, bad, pulses, seen;
    logic [31:0] rd, pa, pw;
    logic er, pwr;
    @(negedge PCLK);
    req = 1'b1; req_write = 1'b0; req_addr = 32'h1000_1000; PREADY = '0;
    @(posedge PCLK);
    #1 req = 1'b0;
    repeat (3) @(negedge PCLK);
    if (PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_access got pen=%b exp 1", PENABLE); end
    checks++;
    #2 PRESET = 1'b1;
    #1;
    if (PSEL !== 4'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got psel=%h pen=%b vld=%b exp 0 0 0", PSEL, PENABLE, rsp_valid);
    end
    checks++;
    @(negedge PCLK);
    PRESET = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge PCLK); if (rsp_valid || !req_ready) seen++; end
    if (seen !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad cycles exp 0", seen); end
    checks++;
    prdata[1] = 32'hCAFE_F00D;
    do_txn(1'b0, 32'h1000_1004, 32'h0, 1, lat, ps, pe, bad, pulses, rd, er, pa, pw, pwr);
    if (rd !== 32'hCAFE_F00D || er !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL rstmid_after got rd=%h err=%b lat=%0d exp cafef00d 0 3", rd, er, lat);
    end
    checks++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) prdata[i] = '0;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    test_reset();
    PRESET = 1'b0;
    test_write_zero_wait();
    test_read_wait();
    test_decode_miss();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
